// File: rtl/rv32_clint_if.sv
// Register port between the interconnect bridge and the CLINT: one request, one response.
interface rv32_clint_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
);
   logic                req_valid_i;
   logic                req_ready_o;
   logic                req_we_i;
   logic [ADDR_W-1:0]   req_addr_i;
   logic [DATA_W-1:0]   req_wdata_i;
   logic [DATA_W/8-1:0] req_wstrb_i;
   logic                rsp_valid_o;
   logic                rsp_ready_i;
   logic [DATA_W-1:0]   rsp_rdata_o;
   logic                rsp_err_o;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );
endinterface

// File: rtl/rv32_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-outstanding register port.
// Response one cycle after accept; a pending response holds req_ready_o low until rsp_ready_i.
module rv32_clint #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 16,
   parameter int PRESCALE = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   rv32_clint_if.slave bus,
   output logic        irq_timer_o,
   output logic        irq_soft_o
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   localparam logic [ADDR_W-1:0] A_MSIP    = ADDR_W'(16'h0000);
   localparam logic [ADDR_W-1:0] A_CMP_LO  = ADDR_W'(16'h4000);
   localparam logic [ADDR_W-1:0] A_CMP_HI  = ADDR_W'(16'h4004);
   localparam logic [ADDR_W-1:0] A_TIME_LO = ADDR_W'(16'hBFF8);
   localparam logic [ADDR_W-1:0] A_TIME_HI = ADDR_W'(16'hBFFC);

   logic [PW-1:0]     presc;
   logic              tick;
   logic [63:0]       mtime, mtime_nxt, mtime_inc;
   logic [63:0]       mtimecmp, mtimecmp_nxt;
   logic              msip, msip_nxt;
   logic              accept, wr, mapped;
   logic [ADDR_W-1:0] word_addr;
   logic              hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
   logic [DATA_W-1:0] rdata_nxt;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   assign bus.req_ready_o = ~bus.rsp_valid_o;
   assign irq_soft_o      = msip;

   always_comb begin
      accept      = bus.req_valid_i & ~bus.rsp_valid_o;
      wr          = accept & bus.req_we_i;
      tick        = (presc == PRESC_MAX);
      word_addr   = bus.req_addr_i & ~ADDR_W'(3);
      hit_msip    = (word_addr == A_MSIP);
      hit_cmp_lo  = (word_addr == A_CMP_LO);
      hit_cmp_hi  = (word_addr == A_CMP_HI);
      hit_time_lo = (word_addr == A_TIME_LO);
      hit_time_hi = (word_addr == A_TIME_HI);
      mapped      = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_time_lo | hit_time_hi;

      rdata_nxt = '0;
      if (!bus.req_we_i) begin
         if (hit_msip)    rdata_nxt = {31'd0, msip};
         if (hit_cmp_lo)  rdata_nxt = mtimecmp[31:0];
         if (hit_cmp_hi)  rdata_nxt = mtimecmp[63:32];
         if (hit_time_lo) rdata_nxt = mtime[31:0];
         if (hit_time_hi) rdata_nxt = mtime[63:32];
      end

      msip_nxt = msip;
      if (wr && hit_msip && bus.req_wstrb_i[0]) msip_nxt = bus.req_wdata_i[0];

      mtimecmp_nxt = mtimecmp;
      if (wr && hit_cmp_lo)
         mtimecmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], bus.req_wdata_i, bus.req_wstrb_i);
      if (wr && hit_cmp_hi)
         mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], bus.req_wdata_i, bus.req_wstrb_i);

      // A real mtime write suppresses that cycle's increment; unwritten bytes keep old value.
      mtime_inc = mtime + 64'd1;
      mtime_nxt = tick ? mtime_inc : mtime;
      if (wr && hit_time_lo && (|bus.req_wstrb_i))
         mtime_nxt = {mtime[63:32], merge_bytes(mtime[31:0], bus.req_wdata_i, bus.req_wstrb_i)};
      if (wr && hit_time_hi && (|bus.req_wstrb_i))
         mtime_nxt = {merge_bytes(mtime[63:32], bus.req_wdata_i, bus.req_wstrb_i), mtime[31:0]};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc           <= '0;
         mtime           <= 64'd0;
         mtimecmp        <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip            <= 1'b0;
         irq_timer_o     <= 1'b0;
         bus.rsp_valid_o <= 1'b0;
         bus.rsp_rdata_o <= '0;
         bus.rsp_err_o   <= 1'b0;
      end else begin
         presc       <= tick ? '0 : presc + PW'(1);
         mtime       <= mtime_nxt;
         mtimecmp    <= mtimecmp_nxt;
         msip        <= msip_nxt;
         irq_timer_o <= (mtime >= mtimecmp);
         if (accept) begin
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_rdata_o <= rdata_nxt;
            bus.rsp_err_o   <= ~mapped;
         end else if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_rv32_clint.sv
// Directed bench for rv32_clint: a PRESCALE=1 instance for register/irq behaviour and a
// PRESCALE=4 instance for the timebase divider.
module tb_rv32_clint;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic irq_t1, irq_s1, irq_t4, irq_s4;
   int   errors = 0;
   int   checks = 0;
   int   cyc;

   rv32_clint_if #(.DATA_W(32), .ADDR_W(16)) bus1 ();
   rv32_clint_if #(.DATA_W(32), .ADDR_W(16)) bus4 ();

   rv32_clint #(.DATA_W(32), .ADDR_W(16), .PRESCALE(1)) u_p1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus1), .irq_timer_o(irq_t1), .irq_soft_o(irq_s1));
   rv32_clint #(.DATA_W(32), .ADDR_W(16), .PRESCALE(4)) u_p4 (
      .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus4), .irq_timer_o(irq_t4), .irq_soft_o(irq_s4));

   always #5 clk_i = ~clk_i;

   // Cycle index since reset release; read at a negedge it names the current cycle.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   // Issues one request on bus1; returns at the negedge of the cycle after accept.
   task automatic bus_xfer(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, output logic [31:0] rd, output logic er,
                           output int acc);
      int n;
      @(negedge clk_i);
      bus1.req_valid_i = 1'b1;
      bus1.req_we_i    = we;
      bus1.req_addr_i  = addr;
      bus1.req_wdata_i = wd;
      bus1.req_wstrb_i = st;
      n = 0;
      while (!bus1.req_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (!bus1.req_ready_o) begin
         checks++; errors++;
         $display("FAIL accept_timeout addr=%h never accepted", addr);
      end
      acc = cyc;
      @(negedge clk_i);
      bus1.req_valid_i = 1'b0;
      rd = bus1.rsp_rdata_o;
      er = bus1.rsp_err_o;
      checks++;
      if (bus1.rsp_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL rsp_latency addr=%h rsp_valid=%b expected 1", addr, bus1.rsp_valid_o);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      checks++;
      if (bus1.rsp_valid_o !== 1'b0 || bus1.rsp_rdata_o !== 32'd0 || bus1.rsp_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp got v=%b d=%h e=%b expected 0/0/0",
                  bus1.rsp_valid_o, bus1.rsp_rdata_o, bus1.rsp_err_o);
      end
      checks++;
      if (bus1.req_ready_o !== 1'b1 || irq_t1 !== 1'b0 || irq_s1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got rdy=%b irq_t=%b irq_s=%b expected 1/0/0",
                  bus1.req_ready_o, irq_t1, irq_s1);
      end
   endtask

   task automatic test_read_time();
      logic [31:0] rd;
      logic        er;
      int          acc;
      bus_xfer(1'b0, 16'hBFF8, 32'd0, 4'h0, rd, er, acc);
      checks++;
      if (rd !== 32'(acc) || er !== 1'b0) begin
         errors++;
         $display("FAIL mtime_lo_read got %h err=%b expected %h err=0", rd, er, 32'(acc));
      end
      bus_xfer(1'b0, 16'h4004, 32'd0, 4'h0, rd, er, acc);
      checks++;
      if (rd !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL mtimecmp_hi_reset got %h expected ffffffff", rd);
      end
      checks++;
      if (irq_t1 !== 1'b0) begin
         errors++;
         $display("FAIL irq_timer_idle got %b expected 0", irq_t1);
      end
   endtask

   task automatic test_timer_irq();
      logic [31:0] rd;
      logic        er;
      int          acc, n;
      bus_xfer(1'b1, 16'h4000, 32'h0000_0040, 4'hF, rd, er, acc);
      bus_xfer(1'b1, 16'h4004, 32'h0000_0000, 4'hF, rd, er, acc);
      checks++;
      if (irq_t1 !== 1'b0) begin
         errors++;
         $display("FAIL irq_timer_early got %b at cycle %0d expected 0", irq_t1, cyc);
      end
      n = 0;
      while (irq_t1 !== 1'b1 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (irq_t1 !== 1'b1 || cyc !== 32'h41) begin
         errors++;
         $display("FAIL irq_timer_rise got irq=%b at cycle %0d expected 1 at cycle 65", irq_t1, cyc);
      end
      bus_xfer(1'b1, 16'h4004, 32'h0000_0001, 4'hF, rd, er, acc);
      checks++;
      if (irq_t1 !== 1'b1) begin
         errors++;
         $display("FAIL irq_timer_lag got %b expected 1 one cycle after cmp write", irq_t1);
      end
      @(negedge clk_i);
      checks++;
      if (irq_t1 !== 1'b0) begin
         errors++;
         $display("FAIL irq_timer_fall got %b expected 0", irq_t1);
      end
   endtask

   task automatic test_soft_irq();
      logic [31:0] rd;
      logic        er;
      int          acc;
      bus_xfer(1'b1, 16'h0000, 32'h0000_0001, 4'hF, rd, er, acc);
      checks++;
      if (irq_s1 !== 1'b1 || rd !== 32'd0 || er !== 1'b0) begin
         errors++;
         $display("FAIL msip_set got irq_s=%b rdata=%h err=%b expected 1/0/0", irq_s1, rd, er);
      end
      bus_xfer(1'b1, 16'h0000, 32'h0000_0000, 4'h0, rd, er, acc);
      checks++;
      if (irq_s1 !== 1'b1 || er !== 1'b0) begin
         errors++;
         $display("FAIL msip_wstrb0 got irq_s=%b err=%b expected 1/0", irq_s1, er);
      end
      bus_xfer(1'b0, 16'h0000, 32'd0, 4'h0, rd, er, acc);
      checks++;
      if (rd !== 32'd1) begin
         errors++;
         $display("FAIL msip_read got %h expected 00000001", rd);
      end
      bus_xfer(1'b1, 16'h0000, 32'hFFFF_FFFE, 4'hF, rd, er, acc);
      checks++;
      if (irq_s1 !== 1'b0) begin
         errors++;
         $display("FAIL msip_clear got %b expected 0", irq_s1);
      end
   endtask

   task automatic test_mtime_carry();
      logic [31:0] rd;
      logic        er;
      logic [63:0] exp;
      int          acc_w, acc;
      bus_xfer(1'b1, 16'hBFFC, 32'h0000_0000, 4'hF, rd, er, acc);
      bus_xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, er, acc_w);
      bus_xfer(1'b0, 16'hBFF8, 32'd0, 4'h0, rd, er, acc);
      exp = 64'h0000_0000_FFFF_FFFF + 64'(acc - acc_w - 1);
      checks++;
      if (rd !== exp[31:0]) begin
         errors++;
         $display("FAIL carry_lo got %h expected %h", rd, exp[31:0]);
      end
      bus_xfer(1'b0, 16'hBFFC, 32'd0, 4'h0, rd, er, acc);
      exp = 64'h0000_0000_FFFF_FFFF + 64'(acc - acc_w - 1);
      checks++;
      if (rd !== exp[63:32] || rd !== 32'd1) begin
         errors++;
         $display("FAIL carry_hi got %h expected %h", rd, exp[63:32]);
      end
      bus_xfer(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, er, acc);
      bus_xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, er, acc_w);
      bus_xfer(1'b0, 16'hBFF8, 32'd0, 4'h0, rd, er, acc);
      exp = 64'hFFFF_FFFF_FFFF_FFFF + 64'(acc - acc_w - 1);
      checks++;
      if (rd !== exp[31:0]) begin
         errors++;
         $display("FAIL wrap_lo got %h expected %h", rd, exp[31:0]);
      end
      bus_xfer(1'b0, 16'hBFFC, 32'd0, 4'h0, rd, er, acc);
      exp = 64'hFFFF_FFFF_FFFF_FFFF + 64'(acc - acc_w - 1);
      checks++;
      if (rd !== exp[63:32] || rd !== 32'd0) begin
         errors++;
         $display("FAIL wrap_hi got %h expected %h", rd, exp[63:32]);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk_i);
      bus1.rsp_ready_i = 1'b0;
      bus1.req_valid_i = 1'b1;
      bus1.req_we_i    = 1'b0;
      bus1.req_addr_i  = 16'h4000;
      bus1.req_wstrb_i = 4'h0;
      @(negedge clk_i);
      bus1.req_addr_i = 16'h4004;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus1.rsp_valid_o !== 1'b1 || bus1.rsp_rdata_o !== 32'h40 || bus1.req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d got v=%b d=%h rdy=%b expected 1/00000040/0",
                     i, bus1.rsp_valid_o, bus1.rsp_rdata_o, bus1.req_ready_o);
         end
         if (i < 4) @(negedge clk_i);
      end
      bus1.rsp_ready_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (bus1.rsp_valid_o !== 1'b0 || bus1.req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL release got v=%b rdy=%b expected 0/1", bus1.rsp_valid_o, bus1.req_ready_o);
      end
      @(negedge clk_i);
      bus1.req_valid_i = 1'b0;
      checks++;
      if (bus1.rsp_valid_o !== 1'b1 || bus1.rsp_rdata_o !== 32'd1) begin
         errors++;
         $display("FAIL second_req got v=%b d=%h expected 1/00000001",
                  bus1.rsp_valid_o, bus1.rsp_rdata_o);
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] rd;
      logic        er;
      int          acc;
      bus_xfer(1'b0, 16'h1234, 32'd0, 4'h0, rd, er, acc);
      checks++;
      if (rd !== 32'd0 || er !== 1'b1) begin
         errors++;
         $display("FAIL unmapped_read got %h err=%b expected 00000000 err=1", rd, er);
      end
      bus_xfer(1'b1, 16'h0004, 32'h0000_0001, 4'hF, rd, er, acc);
      checks++;
      if (er !== 1'b1 || irq_s1 !== 1'b0) begin
         errors++;
         $display("FAIL unmapped_write got err=%b irq_s=%b expected 1/0", er, irq_s1);
      end
      bus_xfer(1'b0, 16'h4002, 32'd0, 4'h0, rd, er, acc);
      checks++;
      if (rd !== 32'h40 || er !== 1'b0) begin
         errors++;
         $display("FAIL addr_low_bits got %h err=%b expected 00000040 err=0", rd, er);
      end
   endtask

   task automatic test_prescale();
      int acc;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         bus4.req_valid_i = 1'b1;
         bus4.req_we_i    = 1'b0;
         bus4.req_addr_i  = 16'hBFF8;
         bus4.req_wstrb_i = 4'h0;
         acc = cyc;
         @(negedge clk_i);
         bus4.req_valid_i = 1'b0;
         checks++;
         if (bus4.rsp_valid_o !== 1'b1 || bus4.rsp_rdata_o !== 32'(acc / 4)) begin
            errors++;
            $display("FAIL prescale_%0d got v=%b d=%h expected 1/%h",
                     i, bus4.rsp_valid_o, bus4.rsp_rdata_o, 32'(acc / 4));
         end
         @(negedge clk_i);
      end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] rd;
      logic        er;
      int          acc;
      bus_xfer(1'b1, 16'h0000, 32'h0000_0001, 4'hF, rd, er, acc);
      @(negedge clk_i);
      bus1.rsp_ready_i = 1'b0;
      bus1.req_valid_i = 1'b1;
      bus1.req_we_i    = 1'b0;
      bus1.req_addr_i  = 16'hBFF8;
      @(negedge clk_i);
      bus1.req_valid_i = 1'b0;
      #1 rst_ni = 1'b0;
      #1;
      checks++;
      if (bus1.rsp_valid_o !== 1'b0 || bus1.req_ready_o !== 1'b1 || irq_s1 !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got v=%b rdy=%b irq_s=%b expected 0/1/0",
                  bus1.rsp_valid_o, bus1.req_ready_o, irq_s1);
      end
      bus1.rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      bus_xfer(1'b0, 16'hBFF8, 32'd0, 4'h0, rd, er, acc);
      checks++;
      if (rd !== 32'(acc)) begin
         errors++;
         $display("FAIL mtime_after_reset got %h expected %h", rd, 32'(acc));
      end
   endtask

   initial begin
      bus1.req_valid_i = 1'b0; bus1.req_we_i = 1'b0; bus1.req_addr_i = '0;
      bus1.req_wdata_i = '0;   bus1.req_wstrb_i = '0; bus1.rsp_ready_i = 1'b1;
      bus4.req_valid_i = 1'b0; bus4.req_we_i = 1'b0; bus4.req_addr_i = '0;
      bus4.req_wdata_i = '0;   bus4.req_wstrb_i = '0; bus4.rsp_ready_i = 1'b1;
      test_reset();
      test_read_time();
      test_timer_irq();
      test_soft_irq();
      test_mtime_carry();
      test_backpressure();
      test_unmapped();
      test_prescale();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rv32_clint.md
Name: rv32_clint

Overview:
Core-local interruptor for the rv32 core. Holds the 64-bit mtime counter, the 64-bit mtimecmp register and the msip bit. Drives the core's irq_timer_i and irq_soft_i lines. Registers are reached through a single-outstanding valid/ready register port, which the interconnect bridges from the core's data AXI.

Parameters:
DATA_W, 32, register port data width; only 32 is supported.
ADDR_W, 16, register port byte-address width (offset within the CLINT window).
PRESCALE, 1, clk_i cycles per mtime increment; must be >= 1.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  1  register request valid
req_ready_o  output  1  register request ready
req_we_i  input  1  1 = write, 0 = read
req_addr_i  input  ADDR_W  byte offset, word aligned
req_wdata_i  input  DATA_W  write data
req_wstrb_i  input  DATA_W/8  byte write enables
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response accepted by requester
rsp_rdata_o  output  DATA_W  read data (0 for writes)
rsp_err_o  output  1  unmapped address
irq_timer_o  output  1  to core irq_timer_i
irq_soft_o  output  1  to core irq_soft_i

Behaviour:
- Clock is clk_i. Reset is rst_ni, asynchronous and active-low.
- Reset values:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip = 0; prescaler = 0.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
  - req_ready_o = 1, irq_timer_o = 0, irq_soft_o = 0.
- Register map (offsets); bits not listed read 0 and ignore writes:
  - 0x0000 msip, bit 0 only.
  - 0x4000 mtimecmp[31:0].
  - 0x4004 mtimecmp[63:32].
  - 0xBFF8 mtime[31:0].
  - 0xBFFC mtime[63:32].
- Other offsets: read data 0, rsp_err_o = 1, writes ignored. req_addr_i[1:0] is ignored.
- Handshake:
  - req_ready_o = ~rsp_valid_o. A request is accepted when req_valid_i && req_ready_o.
  - Response registers are loaded on the accept edge. rsp_valid_o rises the cycle after accept (1-cycle latency).
  - rsp_valid_o, rsp_rdata_o and rsp_err_o hold stable until rsp_valid_o && rsp_ready_i, then rsp_valid_o clears the next cycle.
  - A pending response blocks new requests, so back-to-back throughput is one request every 2 cycles.
- Writes apply byte-wise per req_wstrb_i on the accept edge. wstrb = 0 is a legal no-op with a normal response.
- Reads return register contents as they stand in the accept cycle, i.e. before that cycle's tick or write.
- Timebase:
  - Prescaler counts 0..PRESCALE-1. A tick occurs in the cycle the prescaler equals PRESCALE-1, and the prescaler then returns to 0.
  - Each tick increments mtime by 1, modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0 with no flag.
  - Carry from low to high word happens in the same cycle.
  - With PRESCALE = 1, every cycle is a tick.
- Simultaneous write and tick on mtime: the write wins for written bytes. Unwritten bytes take the values they had before the increment; no increment is applied that cycle.
- Interrupts:
  - irq_timer_o is a register updated every cycle with (mtime >= mtimecmp), 64-bit unsigned, using the current register values. It therefore lags mtime/mtimecmp changes by one cycle.
  - irq_timer_o is level: it stays 1 until mtimecmp is raised above mtime or mtime wraps.
  - irq_soft_o = msip register (registered, no extra lag).
- Reset asserted mid-transaction drops any pending response. All state returns to reset values immediately, asynchronously.

Test Plan:
1. Reset, PRESCALE=1 -> all outputs 0, req_ready_o=1. Read 0xBFF8 accepted at cycle N returns N (cycles counted from reset release, 0-based); read 0x4004 returns 32'hFFFF_FFFF; irq_timer_o stays 0.
2. Write mtimecmp = 64'h0000_0000_0000_0040 (low then high word) -> irq_timer_o rises exactly one cycle after mtime reaches 0x40. Writing mtimecmp high = 1 -> irq_timer_o falls one cycle later.
3. Write 0x0000 = 1 -> irq_soft_o = 1 the cycle after accept. Write with wstrb=4'b0000 -> unchanged. Write 0 -> irq_soft_o = 0.
4. Write mtime low = 32'hFFFF_FFFF and high = 0, then wait one tick -> mtime reads low 0, high 1. Set mtime = all ones -> next tick mtime = 0.
5. Hold rsp_ready_i = 0 for 5 cycles after a read -> rsp_valid_o, rsp_rdata_o stable and req_ready_o = 0. A second req_valid_i is not accepted until the cycle after the rsp handshake.
6. Read 0x1234 -> rdata 0, rsp_err_o = 1. PRESCALE=4 instance: mtime increments once every 4 cycles. Assert rst_ni low with rsp pending -> rsp_valid_o = 0 immediately.
